// File: rtl/apb_mailbox_slave_if.sv
// APB bus bundle for the mailbox responder.
// Signals: PADDR (byte address), PSEL, PENABLE, PWRITE, PWDATA from the
// master; PRDATA, PREADY, PSLVERR from the slave.
interface apb_mailbox_slave_if;
   logic [3:0]  PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_mailbox_slave.sv
// APB mailbox responder: a DEPTH-entry 32-bit FIFO behind four registers
// (CTRL, STATUS, TXDATA, RXDATA), one fixed wait state per transfer.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-high reset
//   bus    - APB slave modport (PADDR/PSEL/PENABLE/PWRITE/PWDATA in,
//            PRDATA/PREADY/PSLVERR out)
//   irq    - level interrupt, CTRL.IE & FIFO not empty
module apb_mailbox_slave #(
   parameter int DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   apb_mailbox_slave_if.slave  bus,
   output logic                irq
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t        state_q, state_d;
   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q;
   logic          ie_q;
   logic [31:0]   prdata_q, prdata_d;
   logic          pslverr_q, pslverr_d;

   logic          empty, full;
   logic [1:0]    reg_sel;
   logic          xfer_err;
   logic [31:0]   rd_word;
   logic          commit, do_push, do_pop, do_ctrl;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign reg_sel = bus.PADDR[3:2];

   always_comb begin
      xfer_err = (bus.PADDR[1:0] != 2'b00)
               | (bus.PWRITE  & (reg_sel == 2'd2) & full)
               | (!bus.PWRITE & (reg_sel == 2'd3) & empty);
      case (reg_sel)
         2'd0:    rd_word = {31'b0, ie_q};
         2'd1:    rd_word = {15'b0, 9'(count_q), 6'b0, full, empty};
         2'd3:    rd_word = mem_q[rptr_q];
         default: rd_word = '0;
      endcase
   end

   // Read data and error are captured only on the WAIT->DONE edge and are
   // cleared on every other edge, so they are zero outside DONE.
   always_comb begin
      state_d   = state_q;
      prdata_d  = '0;
      pslverr_d = 1'b0;
      case (state_q)
         IDLE: if (bus.PSEL && !bus.PENABLE) state_d = WAIT;
         WAIT: begin
            if (!bus.PSEL) begin
               state_d = IDLE;
            end else begin
               state_d   = DONE;
               pslverr_d = xfer_err;
               if (!xfer_err && !bus.PWRITE) prdata_d = rd_word;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Error state was latched on entry to DONE, so an erroring transfer
   // never commits.
   assign commit  = (state_q == DONE) & bus.PSEL & bus.PENABLE & !pslverr_q;
   assign do_push = commit &  bus.PWRITE & (reg_sel == 2'd2);
   assign do_pop  = commit & !bus.PWRITE & (reg_sel == 2'd3);
   assign do_ctrl = commit &  bus.PWRITE & (reg_sel == 2'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
         ie_q      <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
         if (do_ctrl) begin
            ie_q <= bus.PWDATA[0];
            if (bus.PWDATA[1]) begin
               wptr_q  <= '0;
               rptr_q  <= '0;
               count_q <= '0;
            end
         end else if (do_push) begin
            wptr_q  <= wptr_q + AW'(1);
            count_q <= count_q + CW'(1);
         end else if (do_pop) begin
            rptr_q  <= rptr_q + AW'(1);
            count_q <= count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= bus.PWDATA;
   end

   assign bus.PRDATA  = prdata_q;
   assign bus.PSLVERR = pslverr_q;
   assign bus.PREADY  = (state_q == DONE);
   assign irq         = ie_q & !empty;
endmodule

// File: tb/tb_apb_mailbox_slave.sv
module tb_apb_mailbox_slave;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset;
   logic irq;
   int   errors = 0;
   int   checks = 0;

   apb_mailbox_slave_if bus();

   apb_mailbox_slave #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of words plus the IE bit.
   logic [31:0] mq[$];
   bit          m_ie;

   function automatic void model_reset();
      mq.delete();
      m_ie = 1'b0;
   endfunction

   function automatic logic model_irq();
      return m_ie && (mq.size() != 0);
   endfunction

   function automatic void model(input bit wr, input logic [3:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rd, output logic er);
      int r;
      r  = int'(addr[3:2]);
      rd = '0;
      er = 1'b0;
      if (addr[1:0] != 2'b00)                      er = 1'b1;
      else if (wr && r == 2 && mq.size() == DEPTH) er = 1'b1;
      else if (!wr && r == 3 && mq.size() == 0)    er = 1'b1;
      if (!er) begin
         if (wr) begin
            if (r == 0) begin
               m_ie = wdata[0];
               if (wdata[1]) mq.delete();
            end else if (r == 2) begin
               mq.push_back(wdata);
            end
         end else begin
            if (r == 0)      rd = {31'b0, m_ie};
            else if (r == 1) rd = (32'(mq.size()) << 8) | (32'(mq.size() == DEPTH) << 1)
                                  | 32'(mq.size() == 0);
            else if (r == 3) rd = mq.pop_front();
         end
      end
   endfunction

   // One complete APB transfer; returns the sampled response, the model's
   // expectation and the number of access cycles with PREADY low (bounded).
   task automatic bus_xfer(input bit wr, input logic [3:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic er,
                           output logic [31:0] xrd, output logic xer, output int waits);
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = wr;
      bus.PADDR   = addr;
      bus.PWDATA  = wdata;
      @(posedge clk); #1;
      bus.PENABLE = 1'b1;
      waits = 0;
      while (bus.PREADY !== 1'b1 && waits < 5) begin
         waits++;
         @(posedge clk); #1;
      end
      rd = bus.PRDATA;
      er = bus.PSLVERR;
      model(wr, addr, wdata, xrd, xer);
      @(posedge clk); #1;
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
   endtask

   // Protocol monitor: outputs idle-zero and PREADY one cycle wide.
   logic prev_ready = 1'b0;
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         checks++;
         if ((bus.PREADY !== 1'b1 && (bus.PRDATA !== 32'h0 || bus.PSLVERR !== 1'b0))
             || (bus.PREADY === 1'b1 && prev_ready === 1'b1)) begin
            errors++;
            $display("FAIL monitor t=%0t: PREADY=%b prev=%b PRDATA=%h PSLVERR=%b, want idle zeros and single-cycle PREADY",
                     $time, bus.PREADY, prev_ready, bus.PRDATA, bus.PSLVERR);
         end
      end
      prev_ready = bus.PREADY;
   end

   task automatic test_reset();
      logic [31:0] rd, xrd;
      logic er, xer;
      int w;
      reset = 1'b1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      bus.PADDR = '0;  bus.PWDATA = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.PREADY !== 1'b0 || bus.PRDATA !== 32'h0 || bus.PSLVERR !== 1'b0 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: PREADY=%b PRDATA=%h PSLVERR=%b irq=%b, want all 0",
                  bus.PREADY, bus.PRDATA, bus.PSLVERR, irq);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      bus_xfer(1'b0, 4'h4, '0, rd, er, xrd, xer, w);
      checks++;
      if (rd !== 32'h1 || rd !== xrd || er !== 1'b0 || er !== xer || w != 1 || irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_status: PRDATA=%h PSLVERR=%b waits=%0d irq=%b, want PRDATA=00000001 PSLVERR=0 waits=1 irq=0",
                  rd, er, w, irq);
      end
   endtask

   task automatic test_fifo_order();
      bit          wr_t[7] = '{1, 1, 1, 0, 0, 0, 0};
      logic [3:0]  a_t[7]  = '{4'h0, 4'h8, 4'h8, 4'h4, 4'hC, 4'hC, 4'h4};
      logic [31:0] d_t[7]  = '{32'h1, 32'hDEADBEEF, 32'h12345678, 0, 0, 0, 0};
      logic [31:0] got[7];
      logic [31:0] rd, xrd;
      logic er, xer;
      int w;
      for (int i = 0; i < 7; i++) begin
         bus_xfer(wr_t[i], a_t[i], d_t[i], rd, er, xrd, xer, w);
         got[i] = rd;
         checks++;
         if (rd !== xrd || er !== xer || w != 1 || irq !== model_irq()) begin
            errors++;
            $display("FAIL fifo_order[%0d]: PRDATA=%h PSLVERR=%b waits=%0d irq=%b, want PRDATA=%h PSLVERR=%b waits=1 irq=%b",
                     i, rd, er, w, irq, xrd, xer, model_irq());
         end
      end
      checks++;
      if (got[3] !== 32'h200 || got[4] !== 32'hDEADBEEF || got[5] !== 32'h12345678 || got[6] !== 32'h1) begin
         errors++;
         $display("FAIL fifo_order_values: status=%h pop0=%h pop1=%h status=%h, want 00000200 deadbeef 12345678 00000001",
                  got[3], got[4], got[5], got[6]);
      end
   endtask

   task automatic test_full();
      logic [31:0] rd, xrd;
      logic er, xer;
      int w;
      for (int i = 0; i < DEPTH + 4 + DEPTH; i++) begin
         // DEPTH pushes, STATUS, overflow push, STATUS, CTRL read, DEPTH pops
         if (i < DEPTH)              bus_xfer(1'b1, 4'h8, $urandom, rd, er, xrd, xer, w);
         else if (i == DEPTH + 1)    bus_xfer(1'b1, 4'h8, $urandom, rd, er, xrd, xer, w);
         else if (i == DEPTH + 3)    bus_xfer(1'b0, 4'h0, '0, rd, er, xrd, xer, w);
         else if (i < DEPTH + 4)     bus_xfer(1'b0, 4'h4, '0, rd, er, xrd, xer, w);
         else                        bus_xfer(1'b0, 4'hC, '0, rd, er, xrd, xer, w);
         checks++;
         if (rd !== xrd || er !== xer || w != 1 || irq !== model_irq()
             || ((i == DEPTH || i == DEPTH + 2) && rd !== 32'h802)
             || (i == DEPTH + 1 && er !== 1'b1)) begin
            errors++;
            $display("FAIL full[%0d]: PRDATA=%h PSLVERR=%b waits=%0d irq=%b, want PRDATA=%h PSLVERR=%b waits=1 irq=%b",
                     i, rd, er, w, irq, xrd, xer, model_irq());
         end
      end
   endtask

   task automatic test_errors();
      bit          wr_t[8] = '{0, 0, 1, 0, 1, 1, 0, 0};
      logic [3:0]  a_t[8]  = '{4'hC, 4'h9, 4'hA, 4'h4, 4'h4, 4'hC, 4'h8, 4'h4};
      logic [31:0] d_t[8]  = '{0, 0, 32'hCAFEF00D, 0, 32'hFFFFFFFF, 32'h55, 0, 0};
      logic [31:0] rd, xrd;
      logic er, xer;
      int w;
      for (int i = 0; i < 8; i++) begin
         bus_xfer(wr_t[i], a_t[i], d_t[i], rd, er, xrd, xer, w);
         checks++;
         if (rd !== xrd || er !== xer || w != 1 || irq !== model_irq()
             || (i < 3 && (er !== 1'b1 || rd !== 32'h0))) begin
            errors++;
            $display("FAIL errors[%0d]: PRDATA=%h PSLVERR=%b waits=%0d irq=%b, want PRDATA=%h PSLVERR=%b waits=1 irq=%b",
                     i, rd, er, w, irq, xrd, xer, model_irq());
         end
      end
   endtask

   task automatic test_clr();
      bit          wr_t[6] = '{1, 1, 1, 1, 0, 0};
      logic [3:0]  a_t[6]  = '{4'h8, 4'h8, 4'h8, 4'h0, 4'h4, 4'h0};
      logic [31:0] d_t[6];
      logic [31:0] got[6];
      logic [31:0] rd, xrd;
      logic er, xer;
      int w;
      d_t = '{$urandom, $urandom, $urandom, 32'h3, 0, 0};
      for (int i = 0; i < 6; i++) begin
         bus_xfer(wr_t[i], a_t[i], d_t[i], rd, er, xrd, xer, w);
         got[i] = rd;
         checks++;
         if (rd !== xrd || er !== xer || w != 1 || irq !== model_irq()) begin
            errors++;
            $display("FAIL clr[%0d]: PRDATA=%h PSLVERR=%b waits=%0d irq=%b, want PRDATA=%h PSLVERR=%b waits=1 irq=%b",
                     i, rd, er, w, irq, xrd, xer, model_irq());
         end
      end
      checks++;
      if (got[4] !== 32'h1 || got[5] !== 32'h1 || irq !== 1'b0) begin
         errors++;
         $display("FAIL clr_values: STATUS=%h CTRL=%h irq=%b, want 00000001 00000001 0", got[4], got[5], irq);
      end
   endtask

   // Drop PSEL in WAIT (stage 0) or DONE (stage 1): nothing may commit.
   task automatic test_abort();
      logic [31:0] rd, xrd;
      logic er, xer;
      int w;
      for (int stage = 0; stage < 2; stage++) begin
         bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
         bus.PADDR = 4'h8; bus.PWDATA = 32'hA5A5A5A5;
         @(posedge clk); #1;
         bus.PENABLE = 1'b1;
         if (stage == 1) begin
            @(posedge clk); #1;
         end
         bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         bus_xfer(1'b0, 4'h4, '0, rd, er, xrd, xer, w);
         checks++;
         if (rd !== xrd || er !== xer || w != 1 || irq !== model_irq()) begin
            errors++;
            $display("FAIL abort[%0d]: STATUS=%h PSLVERR=%b waits=%0d irq=%b, want STATUS=%h PSLVERR=%b waits=1 irq=%b",
                     stage, rd, er, w, irq, xrd, xer, model_irq());
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, xrd;
      logic er, xer;
      int w, op;
      for (int i = 0; i < 70; i++) begin
         if (i < 40) op = i % 2;
         else        op = int'($urandom_range(0, 3));
         case (op)
            0:       bus_xfer(1'b1, 4'h8, $urandom, rd, er, xrd, xer, w);
            1:       bus_xfer(1'b0, 4'hC, '0, rd, er, xrd, xer, w);
            2:       bus_xfer(1'b0, 4'h4, '0, rd, er, xrd, xer, w);
            default: bus_xfer(1'b1, 4'h0, {30'b0, 1'b0, 1'($urandom)}, rd, er, xrd, xer, w);
         endcase
         checks++;
         if (rd !== xrd || er !== xer || w != 1 || irq !== model_irq()) begin
            errors++;
            $display("FAIL back_to_back[%0d] op=%0d: PRDATA=%h PSLVERR=%b waits=%0d irq=%b, want PRDATA=%h PSLVERR=%b waits=1 irq=%b",
                     i, op, rd, er, w, irq, xrd, xer, model_irq());
         end
      end
   endtask

   // Reset in WAIT (stage 0) and in DONE (stage 1) of a push.
   task automatic test_reset_mid();
      logic [31:0] rd, xrd;
      logic er, xer;
      int w;
      bus_xfer(1'b1, 4'h0, 32'h3, rd, er, xrd, xer, w);
      for (int stage = 0; stage < 2; stage++) begin
         bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
         bus.PADDR = 4'h8; bus.PWDATA = $urandom;
         @(posedge clk); #1;
         bus.PENABLE = 1'b1;
         if (stage == 1) begin
            @(posedge clk); #1;
         end
         #2;
         reset = 1'b1;
         #1;
         checks++;
         if (bus.PREADY !== 1'b0 || bus.PRDATA !== 32'h0 || bus.PSLVERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async[%0d]: PREADY=%b PRDATA=%h PSLVERR=%b, want 0 0 0",
                     stage, bus.PREADY, bus.PRDATA, bus.PSLVERR);
         end
         bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
         @(posedge clk); #1;
         reset = 1'b0;
         model_reset();
         @(posedge clk); #1;
         bus_xfer(1'b0, 4'h4, '0, rd, er, xrd, xer, w);
         checks++;
         if (rd !== 32'h1 || rd !== xrd || er !== xer || w != 1 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_status[%0d]: STATUS=%h PSLVERR=%b waits=%0d irq=%b, want 00000001 0 1 0",
                     stage, rd, er, w, irq);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fifo_order();
      test_full();
      test_errors();
      test_clr();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/apb_mailbox_slave.md
# apb_mailbox_slave

APB responder peripheral that terminates bus transfers issued by the multi-cycle RV32I core's bus master, exposing a DEPTH-entry 32-bit mailbox FIFO behind four word registers. Software pushes words through TXDATA, pops them through RXDATA, and polls STATUS or uses the level interrupt. It is the responder end of the core's load/store bus and carries its own APB phase state machine with one fixed wait state.

## Interface
- DEPTH, default 8: FIFO entries; power of two, 2..256.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- PADDR  in  4  byte address within the peripheral; [3:2] selects the register, [1:0] must be 0.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable (access phase).
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data, valid while PREADY = 1.
- PREADY  out  1  transfer-complete strobe.
- PSLVERR  out  1  error response, valid while PREADY = 1.
- irq  out  1  level interrupt = CTRL.IE & !empty.

## Operation
- Register map:
  - 0x0 CTRL (RW): bit0 IE. Bit1 CLR is write-1 and self-clearing: it empties the FIFO and reads back 0. Other bits read 0.
  - 0x4 STATUS (RO): bit0 empty, bit1 full, bits[16:8] count (0..DEPTH). Other bits 0.
  - 0x8 TXDATA: a write pushes PWDATA; a read returns 0.
  - 0xC RXDATA: a read returns the head entry and pops it; a write is ignored with no error.
- Writes to STATUS are ignored with no error.
- FSM states: IDLE, WAIT, DONE.
  - IDLE → WAIT when PSEL & !PENABLE (setup phase).
  - WAIT → DONE unconditionally. PRDATA and PSLVERR are registered on this edge from the current FIFO/registers.
  - DONE → IDLE unconditionally.
  - In WAIT or DONE, if PSEL = 0 the FSM aborts to IDLE with no side effect.
- Side effects (push, pop, CTRL update) commit on the clock edge that ends DONE, with PSEL & PENABLE & PREADY high.
- PSLVERR = 1 in DONE when any of these holds; the error transfer has no side effect and PRDATA = 0:
  - push to TXDATA while full,
  - read of RXDATA while empty,
  - PADDR[1:0] != 0.
- FIFO storage:
  - Read/write pointers of $clog2(DEPTH) bits wrap modulo DEPTH.
  - Count is $clog2(DEPTH)+1 bits.
  - full = (count == DEPTH); empty = (count == 0).
- CLR resets pointers and count; storage contents are don't-care. IE retains its written value.

## Timing
- Reset values: PREADY 0, PRDATA 0, PSLVERR 0, irq 0, IE 0, count 0, pointers 0, FSM in IDLE.
- Every transfer takes SETUP + 2 access cycles: PREADY is low for the first PENABLE cycle and high for the second (exactly one wait state).
- PREADY is high for exactly one cycle per transfer. PRDATA and PSLVERR are 0 whenever PREADY is 0.
- Back-to-back transfers: a new SETUP may occur the cycle after DONE; IDLE accepts it immediately, so throughput is one transfer per 3 cycles.
- STATUS and irq reflect a push/pop/CLR starting the cycle after the committing edge.
- A read of RXDATA returns the head captured on the WAIT→DONE edge. Because only one transfer is in flight, the head cannot change between capture and pop.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately, PREADY drops asynchronously, and no side effect commits.
- Wrap-around: after DEPTH pushes and DEPTH pops, pointers return to 0 and ordering is preserved.

## Test plan
- Reset, then read STATUS. Expect PRDATA = 0x00000001 (empty), PSLVERR = 0, PREADY high on the 3rd cycle after SETUP, irq = 0.
- Write CTRL = 0x1, push 0xDEADBEEF and 0x12345678. Expect STATUS = 0x00000200 and irq = 1. Pop twice: expect 0xDEADBEEF then 0x12345678 in order, then STATUS = 0x00000001 and irq = 0.
- Push 8 words (DEPTH = 8). Expect STATUS = 0x00000802 (count 8, full). A 9th push gives PSLVERR = 1 and count stays 8.
- Pop from empty. Expect PSLVERR = 1 and PRDATA = 0. Read with PADDR = 0x9. Expect PSLVERR = 1.
- Push 3 words, write CTRL = 0x3. Expect STATUS = 0x00000001, CTRL reads back 0x1, and irq = 0.
- Run 20 push/pop pairs interleaved with back-to-back SETUPs to check pointer wrap and data integrity. Assert reset during a WAIT cycle of a push: expect count unchanged at 0 and PREADY = 0.
